sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for buffering byte or word streams between blocks in the same clock domain. Example uses are the UART TX/RX paths and the bus-side register interface. It adds several features that a basic FIFO lacks: programmable almost-full and almost-empty thresholds, an exact occupancy count, selectable standard or first-word-fall-through (FWFT) read mode, synchronous flush, and overflow/underflow error pulses.

---
 rtl/sync_fifo_pkg.sv | 16 +
 rtl/sync_fifo_mem.sv | 25 ++
 rtl/sync_fifo.sv | 137 +++++++++++++
 tb/tb_sync_fifo.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for sync_fifo: read-mode selectors and an elaboration-time log2 helper.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write port, asynchronous read port, no reset.
module sfifo_mem #(
    parameter int D_SIZE  = 16,
    parameter int F_DEPTH = 8,
    parameter int A_SIZE  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [A_SIZE-1:0] waddr,
    input  logic [D_SIZE-1:0] wdata,
    input  logic [A_SIZE-1:0] raddr,
    output logic [D_SIZE-1:0] rdata
);

    logic [D_SIZE-1:0] mem [F_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable thresholds, flush, error pulses and
// selectable standard or first-word-fall-through read mode.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int D_SIZE   = 16,
    parameter int F_DEPTH  = 8,
    parameter int P_SIZE   = 4,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_flush,
    input  logic              i_w_inc,
    input  logic [D_SIZE-1:0] i_w_data,
    input  logic              i_r_inc,
    output logic [D_SIZE-1:0] o_r_data,
    output logic              o_r_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [P_SIZE-1:0] o_level,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int A_SIZE = P_SIZE - 1;

    if (P_SIZE != clog2(F_DEPTH) + 1) begin : g_bad_p_size
        $error("sync_fifo: P_SIZE must equal clog2(F_DEPTH)+1");
    end
    if (F_DEPTH < 2 || (F_DEPTH & (F_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: F_DEPTH must be a power of 2 and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > F_DEPTH) begin : g_bad_af_level
        $error("sync_fifo: AF_LEVEL out of range 1..F_DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > F_DEPTH - 1) begin : g_bad_ae_level
        $error("sync_fifo: AE_LEVEL out of range 0..F_DEPTH-1");
    end

    logic [P_SIZE-1:0] wr_ptr_q, rd_ptr_q, level_q, level_d;
    logic              full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
    logic              w_acc, r_acc;
    logic [D_SIZE-1:0] mem_rdata;

    // Accept decisions look only at registered flags, never at the other request.
    assign w_acc = i_w_inc && !full_q && !i_flush;
    assign r_acc = i_r_inc && !empty_q && !i_flush;

    always_comb begin
        level_d = level_q;
        if (i_flush) begin
            level_d = '0;
        end else if (w_acc && !r_acc) begin
            level_d = level_q + P_SIZE'(1);
        end else if (r_acc && !w_acc) begin
            level_d = level_q - P_SIZE'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (w_acc) wr_ptr_q <= wr_ptr_q + P_SIZE'(1);
                if (r_acc) rd_ptr_q <= rd_ptr_q + P_SIZE'(1);
            end
            level_q  <= level_d;
            full_q   <= (level_d == P_SIZE'(F_DEPTH));
            empty_q  <= (level_d == '0);
            afull_q  <= (level_d >= P_SIZE'(AF_LEVEL));
            aempty_q <= (level_d <= P_SIZE'(AE_LEVEL));
            ovf_q    <= i_w_inc && full_q && !i_flush;
            unf_q    <= i_r_inc && empty_q && !i_flush;
        end
    end

    sfifo_mem #(
        .D_SIZE  (D_SIZE),
        .F_DEPTH (F_DEPTH),
        .A_SIZE  (A_SIZE)
    ) u_mem (
        .clk   (CLK),
        .we    (w_acc),
        .waddr (wr_ptr_q[A_SIZE-1:0]),
        .wdata (i_w_data),
        .raddr (rd_ptr_q[A_SIZE-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Gated while empty so the unreset array never leaks onto the output.
        assign o_r_data  = empty_q ? '0 : mem_rdata;
        assign o_r_valid = !empty_q;
    end else begin : g_std
        logic [D_SIZE-1:0] r_data_q;
        logic              r_valid_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_valid_q <= r_acc;
                if (r_acc) r_data_q <= mem_rdata;
            end
        end

        assign o_r_data  = r_data_q;
        assign o_r_valid = r_valid_q;
    end

    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_level        = level_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model driven by directed and random steps,
// plus a first-word-fall-through instance.
module tb_sync_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       flush = 1'b0, w_inc = 1'b0, r_inc = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;
    logic       r_valid, full, empty, afull, aempty, ovf, unf;
    logic [3:0] level;

    logic       f_flush = 1'b0, f_w_inc = 1'b0, f_r_inc = 1'b0;
    logic [7:0] f_w_data = '0;
    logic [7:0] f_r_data;
    logic       f_r_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [3:0] f_level;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] exp_data = '0;
    logic       exp_valid = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;

    always #5 CLK = ~CLK;

    sync_fifo #(
        .D_SIZE(8), .F_DEPTH(8), .P_SIZE(4), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)
    ) dut_std (
        .CLK(CLK), .RST(RST), .i_flush(flush), .i_w_inc(w_inc), .i_w_data(w_data),
        .i_r_inc(r_inc), .o_r_data(r_data), .o_r_valid(r_valid), .o_full(full),
        .o_empty(empty), .o_almost_full(afull), .o_almost_empty(aempty), .o_level(level),
        .o_overflow(ovf), .o_underflow(unf)
    );

    sync_fifo #(
        .D_SIZE(8), .F_DEPTH(8), .P_SIZE(4), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)
    ) dut_fwft (
        .CLK(CLK), .RST(RST), .i_flush(f_flush), .i_w_inc(f_w_inc), .i_w_data(f_w_data),
        .i_r_inc(f_r_inc), .o_r_data(f_r_data), .o_r_valid(f_r_valid), .o_full(f_full),
        .o_empty(f_empty), .o_almost_full(f_afull), .o_almost_empty(f_aempty),
        .o_level(f_level), .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".level"}, 32'(level), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".afull"}, 32'(afull), 32'(n >= 6));
        chk({tag, ".aempty"}, 32'(aempty), 32'(n <= 1));
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, ".unf"}, 32'(unf), 32'(exp_unf));
        chk({tag, ".valid"}, 32'(r_valid), 32'(exp_valid));
        chk({tag, ".data"}, 32'(r_data), 32'(exp_data));
    endtask

    // One clock of stimulus on the standard instance, then model update and full check.
    task automatic step(input string tag, input logic w, input logic [7:0] wd, input logic r,
                        input logic fl);
        logic was_full, was_empty;
        w_inc = w; w_data = wd; r_inc = r; flush = fl;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        @(posedge CLK);
        #1;
        if (fl) begin
            q.delete();
            exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        end else begin
            exp_ovf   = w && was_full;
            exp_unf   = r && was_empty;
            exp_valid = r && !was_empty;
            if (r && !was_empty) exp_data = q.pop_front();
            if (w && !was_full) q.push_back(wd);
        end
        w_inc = 1'b0; r_inc = 1'b0; flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        @(posedge CLK);
        #1;
        check_all("reset");
        #2 RST = 1'b0;

        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("ovf_write", 1'b1, 8'hAA, 1'b0, 1'b0);
        step("ovf_pulse_end", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("unf_read", 1'b0, 8'h00, 1'b1, 1'b0);
        step("unf_pulse_end", 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("wrap_prefill", 1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("wrap", 1'b1, 8'($urandom), 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) step("to_full", 1'b1, 8'($urandom), 1'b0, 1'b0);
        step("both_at_full", 1'b1, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("to_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        step("both_at_empty", 1'b1, 8'h44, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step("to_five", 1'b1, 8'($urandom), 1'b0, 1'b0);
        step("flush_with_write", 1'b1, 8'h55, 1'b0, 1'b1);
        step("after_flush", 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step("random", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 24) == 0));
        end

        for (int i = 0; i < 3; i++) step("burst", 1'b1, 8'($urandom), 1'b0, 1'b0);
        step("burst_rd", 1'b1, 8'($urandom), 1'b1, 1'b0);
        w_inc = 1'b1;
        #2 RST = 1'b1;
        #1;
        q.delete();
        exp_data = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        check_all("async_reset");
        chk("async_reset.fwft_valid", 32'(f_r_valid), 32'd0);
        chk("async_reset.fwft_data", 32'(f_r_data), 32'd0);
        w_inc = 1'b0;
        #2 RST = 1'b0;
        step("first_after_reset", 1'b1, 8'h77, 1'b0, 1'b0);
        step("read_after_reset", 1'b0, 8'h00, 1'b1, 1'b0);

        // First-word-fall-through instance.
        chk("fwft_idle.valid", 32'(f_r_valid), 32'd0);
        chk("fwft_idle.empty", 32'(f_empty), 32'd1);
        f_w_inc = 1'b1; f_w_data = 8'h5A;
        @(posedge CLK); #1;
        f_w_inc = 1'b0;
        chk("fwft_write.valid", 32'(f_r_valid), 32'd1);
        chk("fwft_write.data", 32'(f_r_data), 32'h5A);
        chk("fwft_write.level", 32'(f_level), 32'd1);
        @(posedge CLK); #1;
        chk("fwft_hold.valid", 32'(f_r_valid), 32'd1);
        chk("fwft_hold.data", 32'(f_r_data), 32'h5A);
        f_r_inc = 1'b1;
        @(posedge CLK); #1;
        f_r_inc = 1'b0;
        chk("fwft_pop.valid", 32'(f_r_valid), 32'd0);
        chk("fwft_pop.empty", 32'(f_empty), 32'd1);
        chk("fwft_pop.unf", 32'(f_unf), 32'd0);
        f_w_inc = 1'b1; f_w_data = 8'h11;
        @(posedge CLK); #1;
        f_w_data = 8'h22;
        @(posedge CLK); #1;
        f_w_inc = 1'b0; f_r_inc = 1'b1;
        chk("fwft_two.data", 32'(f_r_data), 32'h11);
        chk("fwft_two.level", 32'(f_level), 32'd2);
        @(posedge CLK); #1;
        f_r_inc = 1'b0;
        chk("fwft_next.data", 32'(f_r_data), 32'h22);
        chk("fwft_next.valid", 32'(f_r_valid), 32'd1);
        chk("fwft_next.level", 32'(f_level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
